// File: rtl/adder_tree_arbiter_if.sv
// rtl/adder_tree_arbiter_if.sv - requester-side request/response bundle for adder_tree_arbiter
interface adder_tree_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]    req;
    logic [N*64-1:0] req_ops;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rsp_valid;
    logic [N*12-1:0] rsp_data;
    logic [N-1:0]    rsp_ack;

    // requester blocks drive requests and acks
    modport master (
        output req, req_ops, rsp_ack,
        input  gnt, rsp_valid, rsp_data
    );

    // arbiter side
    modport slave (
        input  req, req_ops, rsp_ack,
        output gnt, rsp_valid, rsp_data
    );
endinterface

// File: rtl/adder_tree_arbiter.sv
// rtl/adder_tree_arbiter.sv - round-robin sharing of one pipelined 8-input adder tree among N requesters
module adder_tree_arbiter #(
    parameter int N        = 4,
    parameter int TREE_LAT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_tree_arbiter_if.slave  rq,
    output logic [63:0]          tree_ops,
    input  logic [11:0]          tree_sum
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0]              last_gnt_q, last_gnt_d;
    logic [N-1:0]               gnt_q, gnt_d;
    logic [63:0]                tree_ops_q, tree_ops_d;
    logic [TREE_LAT:0]          tag_vld_q, tag_vld_d;
    logic [TREE_LAT:0][IW-1:0]  tag_id_q, tag_id_d;
    logic [N-1:0]               rsp_valid_q, rsp_valid_d;
    logic [N-1:0][11:0]         rsp_data_q, rsp_data_d;

    logic [N-1:0]               busy;
    logic [N-1:0]               elig;
    logic                       found;
    logic [IW-1:0]              win;
    logic [IW-1:0]              cand;

    // a requester is busy while its tag is anywhere in the pipe or its slot holds a result
    always_comb begin
        busy = rsp_valid_q;
        for (int s = 0; s <= TREE_LAT; s++) begin
            if (tag_vld_q[s]) begin
                busy[tag_id_q[s]] = 1'b1;
            end
        end
    end

    assign elig = rq.req & ~busy;

    // round-robin search starting one past the last issued requester
    always_comb begin
        found = 1'b0;
        win   = last_gnt_q;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_gnt_q) + k) % N);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // next-state: issue, tag shift, result capture and ack clear
    always_comb begin
        last_gnt_d  = last_gnt_q;
        gnt_d       = '0;
        tree_ops_d  = '0;
        if (found) begin
            last_gnt_d = win;
            gnt_d[win] = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (win == IW'(i)) begin
                    tree_ops_d = rq.req_ops[64*i +: 64];
                end
            end
        end

        tag_vld_d = {tag_vld_q[TREE_LAT-1:0], found};
        tag_id_d  = {tag_id_q[TREE_LAT-1:0], win};

        // ack and capture never target the same slot: a valid slot blocks issue
        rsp_valid_d = rsp_valid_q & ~rq.rsp_ack;
        rsp_data_d  = rsp_data_q;
        if (tag_vld_q[TREE_LAT]) begin
            rsp_valid_d[tag_id_q[TREE_LAT]] = 1'b1;
            rsp_data_d[tag_id_q[TREE_LAT]]  = tree_sum;
        end
    end

    // state registers; reset discards in-flight tags and held results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q  <= IW'(N - 1);
            gnt_q       <= '0;
            tree_ops_q  <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            gnt_q       <= gnt_d;
            tree_ops_q  <= tree_ops_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rq.gnt       = gnt_q;
    assign rq.rsp_valid = rsp_valid_q;
    assign rq.rsp_data  = rsp_data_q;
    assign tree_ops     = tree_ops_q;

endmodule

// File: tb/tb_adder_tree_arbiter.sv
// tb/tb_adder_tree_arbiter.sv - directed and random checks of adder_tree_arbiter against a cycle model
module tb_adder_tree_arbiter;
    localparam int N  = 4;
    localparam int TL = 3;
    localparam int IW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] tree_ops;
    logic [11:0] tree_sum;
    logic [11:0] tp0, tp1, tp2;

    adder_tree_arbiter_if #(.N(N)) bus ();

    adder_tree_arbiter #(.N(N), .TREE_LAT(TL)) dut (
        .clk      (clk),
        .rst      (rst),
        .rq       (bus),
        .tree_ops (tree_ops),
        .tree_sum (tree_sum)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bytesum(input logic [63:0] v);
        int s;
        s = 0;
        for (int k = 0; k < 8; k++) s += int'(v[8*k +: 8]);
        return 12'(s);
    endfunction

    // external adder tree: three register stages, never reset
    always @(posedge clk) begin
        tp0 <= bytesum(tree_ops);
        tp1 <= tp0;
        tp2 <= tp1;
    end
    assign tree_sum = tp2;

    int          ncheck = 0;
    int          npass  = 0;
    int          nfail  = 0;
    int          ecnt   = 0;
    int          m_last;
    bit          m_fly   [N];
    int          m_due   [N];
    logic [11:0] m_sum   [N];
    bit          m_val   [N];
    logic [11:0] m_dat   [N];
    bit          granted [N];
    int          gc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1;
        for (int i = 0; i < N; i++) begin
            m_fly[i]   = 1'b0;
            m_val[i]   = 1'b0;
            m_dat[i]   = '0;
            m_due[i]   = 0;
            m_sum[i]   = '0;
            granted[i] = 1'b0;
        end
    endtask

    // one clock: predict from the rules, advance, compare all outputs; returns at negedge
    task automatic step();
        logic [N-1:0]    busy;
        logic [N-1:0]    elig;
        logic [N-1:0]    e_gnt;
        logic [63:0]     e_ops;
        logic [N-1:0]    e_val;
        logic [N*12-1:0] e_dat;
        logic [IW-1:0]   wi;
        int              w;
        int              c;
        for (int i = 0; i < N; i++) busy[i] = m_fly[i] | m_val[i];
        elig = bus.req & ~busy;
        w = -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_last + k) % N;
            if (w < 0 && elig[IW'(c)]) w = c;
        end
        @(posedge clk);
        ecnt++;
        for (int i = 0; i < N; i++) if (m_val[i] && bus.rsp_ack[i]) m_val[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_fly[i] && m_due[i] == ecnt) begin
                m_fly[i] = 1'b0;
                m_val[i] = 1'b1;
                m_dat[i] = m_sum[i];
            end
        end
        e_gnt = '0;
        e_ops = '0;
        if (w >= 0) begin
            wi           = IW'(w);
            e_ops        = bus.req_ops[64*w +: 64];
            e_gnt[wi]    = 1'b1;
            m_fly[wi]    = 1'b1;
            m_due[wi]    = ecnt + TL + 1;
            m_sum[wi]    = bytesum(e_ops);
            granted[wi]  = 1'b1;
            m_last       = w;
        end
        #1;
        for (int i = 0; i < N; i++) begin
            e_val[i]        = m_val[i];
            e_dat[12*i +: 12] = m_dat[i];
        end
        chk("gnt",       64'(bus.gnt),       64'(e_gnt));
        chk("tree_ops",  tree_ops,           e_ops);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(e_val));
        chk("rsp_data",  64'(bus.rsp_data),  64'(e_dat));
        @(negedge clk);
    endtask

    // asynchronous assertion mid-cycle, release on a later negedge
    task automatic reset_async();
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_gnt",       64'(bus.gnt),       64'd0);
        chk("rst_tree_ops",  tree_ops,           64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bus.req     = '0;
        bus.req_ops = '0;
        bus.rsp_ack = '0;
        model_reset();
        @(negedge clk);
        reset_async();

        // single request, all bytes 1
        bus.req[0] = 1'b1;
        bus.req_ops[63:0] = 64'h0101_0101_0101_0101;
        step();
        chk("single_gnt", 64'(bus.gnt), 64'h1);
        repeat (3) step();
        chk("single_not_yet", 64'(bus.rsp_valid), 64'h0);
        step();
        chk("single_valid", 64'(bus.rsp_valid), 64'h1);
        chk("single_data", 64'(bus.rsp_data[11:0]), 64'h008);
        gc = 0;
        repeat (3) begin
            step();
            if (bus.gnt[0]) gc++;
        end
        chk("single_no_regnt", 64'(gc), 64'd0);
        chk("single_held", 64'(bus.rsp_valid), 64'h1);
        bus.rsp_ack[0] = 1'b1;
        bus.req[0]     = 1'b0;
        step();
        bus.rsp_ack = '0;
        chk("single_acked", 64'(bus.rsp_valid), 64'h0);

        // maximum sum on requester 2
        bus.req[2] = 1'b1;
        bus.req_ops[128 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        bus.req[2] = 1'b0;
        repeat (4) step();
        chk("max_valid", 64'(bus.rsp_valid), 64'h4);
        chk("max_data", 64'(bus.rsp_data[35:24]), 64'h7F8);
        bus.rsp_ack[2] = 1'b1;
        step();
        bus.rsp_ack = '0;

        // fairness from reset: all request together
        reset_async();
        for (int i = 0; i < N; i++) begin
            bus.req[i] = 1'b1;
            bus.req_ops[64*i +: 64] = {8{8'(i + 1)}};
        end
        for (int k = 0; k < N; k++) begin
            step();
            chk("rr_order", 64'(bus.gnt), 64'(1) << k);
            bus.req[k] = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            step();
            chk("rr_results", 64'(bus.rsp_valid), (64'(1) << (k + 1)) - 64'd1);
        end
        chk("rr_sums", 64'(bus.rsp_data), {16'd0, 12'd32, 12'd24, 12'd16, 12'd8});

        // pointer rotation after requester 3
        bus.rsp_ack = '1;
        step();
        bus.rsp_ack = '0;
        bus.req[1] = 1'b1;
        bus.req[3] = 1'b1;
        bus.req_ops[64 +: 64]  = {$urandom(), $urandom()};
        bus.req_ops[192 +: 64] = {$urandom(), $urandom()};
        step();
        chk("rot_first", 64'(bus.gnt), 64'h2);
        bus.req[1] = 1'b0;
        step();
        chk("rot_second", 64'(bus.gnt), 64'h8);
        bus.req[3] = 1'b0;
        repeat (5) step();
        bus.rsp_ack = '1;
        step();
        bus.rsp_ack = '0;

        // a held slot blocks re-issue until acked
        bus.req[0] = 1'b1;
        bus.req_ops[63:0] = {$urandom(), $urandom()};
        step();
        repeat (4) step();
        chk("hold_valid", 64'(bus.rsp_valid[0]), 64'h1);
        gc = 0;
        repeat (10) begin
            step();
            if (bus.gnt[0]) gc++;
        end
        chk("hold_blocked", 64'(gc), 64'd0);
        bus.rsp_ack[0] = 1'b1;
        step();
        chk("hold_ack_edge_gnt", 64'(bus.gnt[0]), 64'h0);
        chk("hold_ack_clear", 64'(bus.rsp_valid[0]), 64'h0);
        bus.rsp_ack = '0;
        step();
        chk("hold_reissue", 64'(bus.gnt), 64'h1);
        bus.req[0] = 1'b0;
        repeat (5) step();
        bus.rsp_ack = '1;
        step();
        bus.rsp_ack = '0;

        // reset two cycles after an issue discards the result
        bus.req[1] = 1'b1;
        step();
        chk("mid_gnt", 64'(bus.gnt), 64'h2);
        bus.req[1] = 1'b0;
        repeat (2) step();
        reset_async();
        repeat (6) step();
        chk("mid_no_valid", 64'(bus.rsp_valid), 64'h0);
        bus.req[0] = 1'b1;
        bus.req[1] = 1'b1;
        step();
        chk("mid_first_gnt", 64'(bus.gnt), 64'h1);
        step();
        bus.req = '0;

        // random traffic: requests hold until granted, acks arrive at random
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(bus.req[i] && !granted[i])) begin
                    bus.req[i] = ($urandom_range(0, 2) != 0);
                    bus.req_ops[64*i +: 64] = {$urandom(), $urandom()};
                    granted[i] = 1'b0;
                end
                bus.rsp_ack[i] = ($urandom_range(0, 2) == 0);
            end
            step();
        end

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end
endmodule

// File: doc/adder_tree_arbiter.md
# adder_tree_arbiter

Round-robin arbiter that shares the single 3-stage pipelined 8-input adder tree (8×8-bit operands, 12-bit sum, 3-cycle latency) among N requesters. It accepts one operand vector per cycle from the winning requester and drives the tree's operand inputs. It carries a requester tag alongside the tree pipeline and returns each 12-bit sum to its owner through a per-requester valid/ack response slot. It sits between the requester blocks and the adder tree at the top level; the tree is instantiated outside this block.

## Interface
- N, 4, number of requesters (2..8)
- TREE_LAT, 3, adder tree latency in cycles from operand change to sum change
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  N  requester i has an operand vector pending
- req_ops  in  N*64  requester i operands at [64*i+:64]; byte k = tree input k (in0 = bits [7:0])
- gnt  out  N  one-cycle pulse, requester i's operands were issued
- tree_ops  out  64  registered operand vector to the adder tree, same byte order
- tree_sum  in  12  adder tree sum output
- rsp_valid  out  N  result for requester i held in its slot
- rsp_data  out  N*12  result for requester i at [12*i+:12]
- rsp_ack  in  N  requester i consumes its result

## Operation
- Each requester has at most one transaction outstanding. busy[i] = tag in flight for i OR rsp_valid[i].
- Eligible[i] = req[i] & ~busy[i], evaluated from current-cycle registered state.
- Arbitration: round-robin. The search starts at last_gnt+1 mod N. The first eligible requester wins. last_gnt updates only on an issue.
- Issue at edge E:
  - tree_ops <= winner's operands.
  - gnt <= one-hot of winner.
  - Tag stage 0 <= {valid=1, id=winner}.
- No eligible requester at edge E:
  - tree_ops <= 0.
  - gnt <= 0.
  - Tag stage 0 valid <= 0.
- Tag pipeline: TREE_LAT+1 stages (stage 0..TREE_LAT), shifting every cycle unconditionally.
- Capture: when stage TREE_LAT is valid at edge E+TREE_LAT+1:
  - rsp_data[id] <= tree_sum.
  - rsp_valid[id] <= 1.
- rsp_valid[i] clears at the edge where rsp_valid[i] & rsp_ack[i]. An ack without valid is ignored.
- Requester protocol:
  - Hold req and req_ops stable until gnt is observed.
  - req may remain high afterwards. busy blocks re-issue, so no duplicate occurs.
  - Operand changes after gnt have no effect.
- Sum width: the 12-bit result is exact; maximum is 8×255 = 2040.
- Requesters must not drop req before gnt; behaviour is undefined if they do.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert assumed at top):
  - gnt = 0, tree_ops = 0, rsp_valid = 0, rsp_data = 0.
  - All tags invalid.
  - last_gnt = N-1, so requester 0 has first priority.
- Issue latency: req high with the requester idle at edge E-1 gives gnt and tree_ops valid after edge E.
- Result latency: rsp_valid rises after edge E+TREE_LAT+1, i.e. 4 cycles after the gnt edge.
- Re-issue: ack sampled at edge A clears rsp_valid at A. The earliest re-issue for that requester is edge A+1.
- Throughput: one issue per cycle across requesters. Full rate is sustained when N ≥ 6 or acks return promptly.
- Reset mid-operation:
  - All in-flight tags and held results are discarded.
  - No rsp_valid is produced for a pre-reset issue, even though the tree pipeline may still hold stale data.
- An issue and a capture for different requesters on the same edge are both performed.
- An ack for i and a capture for j≠i on the same edge are both performed.

## Test plan
- Single request: reset, then req[0]=1 with all operand bytes = 0x01 → gnt[0] pulses for one cycle. 4 cycles later rsp_valid[0]=1, rsp_data[0]=0x008, held until rsp_ack[0]. No second gnt while req[0] stays high.
- Max value: requester 2 operands all 0xFF → rsp_data[2]=2040 (0x7F8), rsp_valid only on bit 2.
- Round-robin fairness:
  - N=4, all req high at once, distinct operands (requester i bytes = i+1) → gnt order 0,1,2,3 on consecutive cycles.
  - Results arrive on consecutive cycles with sums 8, 16, 24, 32 in slots 0..3.
- Pointer rotation: after the previous test, ack all, then raise req[1] and req[3] together → gnt[1] first, then gnt[3] the next cycle.
- Held slot blocks: withhold rsp_ack[0] and keep req[0] high for 10 cycles → no further gnt[0]. Ack at edge A → gnt[0] at edge A+1.
- Reset mid-flight: assert rst 2 cycles after gnt[1] → no rsp_valid appears afterwards, tree_ops=0, and the next grant after reset goes to requester 0 when requester 0 is requesting.
